dot_prod_main: RTL and testbench
================================

Name: dot_prod_main

Overview:
- Signed dot-product engine over two on-chip 1024 x 27-bit vector memories, A and B.
- A host-control mode lets the testbench or host load and read both memories directly.
- In compute mode, a start pulse runs a sequential multiply-accumulate over elements init_i..N-1, starting from init_acc.
- A one-cycle w_enable pulse then presents the 64-bit result.

Parameters:
- N, 1000, number of elements; the loop runs while index < N.
- DEPTH, 1024, words per memory (address width 10).
- DW, 27, signed data width of each memory word.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- r_enable  in  1  start pulse.
- controlArr  in  1  1 = host owns both memories; 0 = engine owns them.
- init_i  in  64  start index.
- init_acc  in  64  initial accumulator value.
- w_enable  out  1  one-cycle done strobe.
- result  out  64  final accumulator, two's complement.
- controlArrWEnable_a  in  1  host write enable, memory A.
- controlArrAddr_a  in  10  host address, memory A.
- controlArrWData_a  in  27 signed  host write data, memory A.
- controlArrRData_a  out  27 signed  memory A read data.
- controlArrWEnable_b, controlArrAddr_b, controlArrWData_b, controlArrRData_b: same as the A ports, for memory B.

Behaviour:
- Memories: single-port, synchronous write, synchronous read (1-cycle latency); no reset of contents.
- Port ownership, while not busy:
  - controlArr=1: host ports drive address, write enable and write data; write occurs at the edge when WEnable=1.
  - controlArr=0: engine drives address; write enable is forced 0.
- While busy, the engine owns both memories regardless of controlArr; host writes are ignored.
- controlArrRData_x always shows the registered read data of memory x.
- Reset: state=IDLE, w_enable=0, result=0, internal i=0, acc=0.
- FSM IDLE:
  - At an edge with r_enable=1 and controlArr=0: latch i<=init_i, acc<=init_acc, go to CHECK.
  - r_enable while controlArr=1 is ignored.
- FSM CHECK:
  - If i >= N (unsigned 64-bit compare): go to DONE.
  - Else present address i[9:0] to both memories, go to MAC.
- FSM MAC:
  - Read data is valid this cycle. Compute prod = signed(a) * signed(b), 54-bit signed, sign-extended to 64.
  - acc <= acc + prod, modulo 2^64 (wraps, no saturation).
  - i <= i+1; go to CHECK.
- FSM DONE: w_enable=1 for exactly this cycle and result<=acc (visible in the same cycle as w_enable); go to IDLE.
- result holds its value until the next DONE or reset.
- Latency from the start edge to the w_enable cycle: 2*(N - init_i) + 2 cycles when init_i < N; 2 cycles when init_i >= N.
- r_enable during a run is ignored; there is no abort.
- Reset mid-run returns to IDLE with no w_enable and result=0. Memory contents are preserved.
- A start and a host write in the same cycle: host write is performed (controlArr must be 1), so no start occurs.

Test Plan:
- Load A[k]=1, B[k]=1 for k=0..999; start with init_i=0, init_acc=0 -> w_enable after 2002 cycles, result=1000.
- Load A[k]=-(2^26), B[k]=-(2^26) for all k (max-magnitude values); start -> result = 1000*2^52 = 4503599627370496000.
- Random full-range signed A,B (1000 words); deassert controlArr and pulse r_enable in the same cycle -> result equals the 64-bit signed sum of A[k]*B[k]; w_enable high exactly one cycle.
- init_i=998, init_acc=5, A[998]=3, B[998]=-4, A[999]=7, B[999]=2 -> result=5-12+14=7, latency 6 cycles.
- init_i=1000, init_acc=-9 -> result=-9 after 2 cycles, no memory access; then host write/readback of A[5]=12345 -> RData_a=12345 one cycle after the address is presented.
- Assert reset at cycle 100 of a run -> w_enable never pulses, result=0; a re-run afterwards gives the correct sum.

Source files
------------

// File: rtl/dot_prod_main.sv
// dot_prod_main
//   Signed dot-product engine over two 1024 x 27-bit on-chip memories (A, B).
//   With controlArr=1 and the engine idle, the host reads and writes both
//   memories through the controlArr* ports. With controlArr=0, a start pulse
//   runs acc += A[i]*B[i] for i = init_i .. N-1, starting from init_acc. A
//   one-cycle w_enable strobe then presents the 64-bit result.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   r_enable              start pulse (ignored while controlArr=1 or busy)
//   controlArr            1 = host owns memories, 0 = engine owns them
//   init_i, init_acc      start index and initial accumulator
//   w_enable, result      one-cycle done strobe and final accumulator
//   controlArrWEnable_x   host write enable, memory x (a/b)
//   controlArrAddr_x      host address, memory x
//   controlArrWData_x     host write data, memory x
//   controlArrRData_x     registered read data of memory x
module dot_prod_main #(
    parameter int N     = 1000,
    parameter int DEPTH = 1024,
    parameter int DW    = 27
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        r_enable,
    input  logic                        controlArr,
    input  logic [63:0]                 init_i,
    input  logic [63:0]                 init_acc,
    output logic                        w_enable,
    output logic [63:0]                 result,
    input  logic                        controlArrWEnable_a,
    input  logic [$clog2(DEPTH)-1:0]    controlArrAddr_a,
    input  logic signed [DW-1:0]        controlArrWData_a,
    output logic signed [DW-1:0]        controlArrRData_a,
    input  logic                        controlArrWEnable_b,
    input  logic [$clog2(DEPTH)-1:0]    controlArrAddr_b,
    input  logic signed [DW-1:0]        controlArrWData_b,
    output logic signed [DW-1:0]        controlArrRData_b
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = 2 * DW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_MAC,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] i_q, i_d;
    logic [63:0] acc_q, acc_d;
    logic [63:0] result_q, result_d;
    logic        w_enable_q, w_enable_d;

    logic                 host_own;
    logic [AW-1:0]        addr_a, addr_b;
    logic                 we_a, we_b;
    logic signed [DW-1:0] mem_a [DEPTH];
    logic signed [DW-1:0] mem_b [DEPTH];
    logic signed [DW-1:0] rdata_a_q, rdata_b_q;
    logic signed [PW-1:0] prod;
    logic [63:0]          prod_ext;

    // Host only owns the memories while the engine is idle; a running
    // engine keeps the address on i and blocks all writes.
    always_comb begin
        host_own = controlArr && (state_q == S_IDLE);
        if (host_own) begin
            addr_a = controlArrAddr_a;
            addr_b = controlArrAddr_b;
            we_a   = controlArrWEnable_a;
            we_b   = controlArrWEnable_b;
        end else begin
            addr_a = i_q[AW-1:0];
            addr_b = i_q[AW-1:0];
            we_a   = 1'b0;
            we_b   = 1'b0;
        end
    end

    // Single-port memories, synchronous write and registered read.
    always_ff @(posedge clk) begin
        if (we_a) begin
            mem_a[addr_a] <= controlArrWData_a;
        end
        rdata_a_q <= mem_a[addr_a];
    end

    always_ff @(posedge clk) begin
        if (we_b) begin
            mem_b[addr_b] <= controlArrWData_b;
        end
        rdata_b_q <= mem_b[addr_b];
    end

    always_comb begin
        prod     = rdata_a_q * rdata_b_q;
        prod_ext = {{(64 - PW){prod[PW-1]}}, prod};
    end

    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        acc_d      = acc_q;
        result_d   = result_q;
        w_enable_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (r_enable && !controlArr) begin
                    i_d     = init_i;
                    acc_d   = init_acc;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                // Outputs are registered, so the DONE-cycle strobe and
                // result are loaded on the transition into DONE.
                if (i_q >= 64'(N)) begin
                    state_d    = S_DONE;
                    w_enable_d = 1'b1;
                    result_d   = acc_q;
                end else begin
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                acc_d   = acc_q + prod_ext;
                i_d     = i_q + 64'd1;
                state_d = S_CHECK;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            i_q        <= '0;
            acc_q      <= '0;
            result_q   <= '0;
            w_enable_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            acc_q      <= acc_d;
            result_q   <= result_d;
            w_enable_q <= w_enable_d;
        end
    end

    assign w_enable          = w_enable_q;
    assign result            = result_q;
    assign controlArrRData_a = rdata_a_q;
    assign controlArrRData_b = rdata_b_q;

endmodule

// File: tb/tb_dot_prod_main.sv
// tb_dot_prod_main
//   Self-checking bench for dot_prod_main: table-driven full-vector runs
//   (all-ones, max-magnitude, random) plus hand sequences for the tail
//   start, skip start, host readback, ignored start and mid-run reset.
module tb_dot_prod_main;

    localparam int N     = 1000;
    localparam int DEPTH = 1024;
    localparam int DW    = 27;

    logic                 clk;
    logic                 reset;
    logic                 r_enable;
    logic                 controlArr;
    logic [63:0]          init_i;
    logic [63:0]          init_acc;
    logic                 w_enable;
    logic [63:0]          result;
    logic                 controlArrWEnable_a;
    logic [9:0]           controlArrAddr_a;
    logic signed [DW-1:0] controlArrWData_a;
    logic signed [DW-1:0] controlArrRData_a;
    logic                 controlArrWEnable_b;
    logic [9:0]           controlArrAddr_b;
    logic signed [DW-1:0] controlArrWData_b;
    logic signed [DW-1:0] controlArrRData_b;

    dot_prod_main #(.N(N), .DEPTH(DEPTH), .DW(DW)) dut (
        .clk                 (clk),
        .reset               (reset),
        .r_enable            (r_enable),
        .controlArr          (controlArr),
        .init_i              (init_i),
        .init_acc            (init_acc),
        .w_enable            (w_enable),
        .result              (result),
        .controlArrWEnable_a (controlArrWEnable_a),
        .controlArrAddr_a    (controlArrAddr_a),
        .controlArrWData_a   (controlArrWData_a),
        .controlArrRData_a   (controlArrRData_a),
        .controlArrWEnable_b (controlArrWEnable_b),
        .controlArrAddr_b    (controlArrAddr_b),
        .controlArrWData_b   (controlArrWData_b),
        .controlArrRData_b   (controlArrRData_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic signed [DW-1:0] ref_a [DEPTH];
    logic signed [DW-1:0] ref_b [DEPTH];
    logic [63:0]          exp_q [$];

    typedef struct {
        int          kind;       // 0 = all ones, 1 = max negative, 2 = random
        logic [63:0] start_i;
        logic [63:0] start_acc;
        logic [63:0] exp_result;
        int          exp_lat;
        bit          use_model;
    } vec_t;

    vec_t vecs [3];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    task automatic host_wr(input logic wa, input logic wb, input logic [9:0] addr,
                           input logic signed [DW-1:0] va, input logic signed [DW-1:0] vb);
        controlArr          = 1'b1;
        controlArrWEnable_a = wa;
        controlArrWEnable_b = wb;
        controlArrAddr_a    = addr;
        controlArrAddr_b    = addr;
        controlArrWData_a   = va;
        controlArrWData_b   = vb;
        tick();
        controlArrWEnable_a = 1'b0;
        controlArrWEnable_b = 1'b0;
        if (wa) ref_a[addr] = va;
        if (wb) ref_b[addr] = vb;
    endtask

    task automatic load(input int kind);
        logic signed [DW-1:0] va, vb, mn;
        mn = '0;
        mn[DW-1] = 1'b1;
        for (int k = 0; k < N; k++) begin
            case (kind)
                0:       begin va = 27'sd1; vb = 27'sd1; end
                1:       begin va = mn;     vb = mn;     end
                default: begin va = 27'($urandom()); vb = 27'($urandom()); end
            endcase
            host_wr(1'b1, 1'b1, 10'(k), va, vb);
        end
    endtask

    function automatic logic [63:0] model(input logic [63:0] si, input logic [63:0] sa);
        logic [63:0] acc;
        acc = sa;
        if (si < 64'(N)) begin
            for (int unsigned k = si[31:0]; k < N; k++) begin
                acc = acc + 64'(longint'(ref_a[k]) * longint'(ref_b[k]));
            end
        end
        return acc;
    endfunction

    // Start a run (controlArr drops in the start cycle), wait for the strobe,
    // and check result, latency, strobe width and result hold. With poke set
    // the host tries to clobber A[999] while the engine is busy.
    task automatic run(input string name, input logic [63:0] si, input logic [63:0] sa,
                       input logic [63:0] exp_res, input int exp_lat, input bit poke);
        int          cnt;
        bit          seen;
        logic [63:0] exp;
        init_i     = si;
        init_acc   = sa;
        controlArr = 1'b0;
        r_enable   = 1'b1;
        exp_q.push_back(exp_res);
        cnt  = 0;
        seen = 1'b0;
        while (!seen && cnt < 3000) begin
            tick();
            cnt++;
            r_enable = 1'b0;
            if (poke && cnt == 1) begin
                controlArr          = 1'b1;
                controlArrWEnable_a = 1'b1;
                controlArrAddr_a    = 10'd999;
                controlArrWData_a   = '0;
            end else if (poke && cnt == 2) begin
                controlArrWEnable_a = 1'b0;
                controlArr          = 1'b0;
            end
            if (w_enable) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no w_enable expected w_enable within 3000 cycles", name);
            void'(exp_q.pop_front());
        end else if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_scoreboard: got w_enable expected no pending result", name);
        end else begin
            exp = exp_q.pop_front();
            chk({name, "_result"}, result, exp);
            chk({name, "_latency"}, 64'(cnt), 64'(exp_lat));
            tick();
            chk({name, "_strobe_width"}, 64'(w_enable), 64'd0);
            chk({name, "_result_hold"}, result, exp);
        end
    endtask

    initial begin
        int hi;
        reset               = 1'b1;
        r_enable            = 1'b0;
        controlArr          = 1'b1;
        init_i              = '0;
        init_acc            = '0;
        controlArrWEnable_a = 1'b0;
        controlArrWEnable_b = 1'b0;
        controlArrAddr_a    = '0;
        controlArrAddr_b    = '0;
        controlArrWData_a   = '0;
        controlArrWData_b   = '0;
        repeat (3) tick();
        chk("reset_w_enable", 64'(w_enable), 64'd0);
        chk("reset_result", result, 64'd0);
        reset = 1'b0;
        tick();

        vecs[0] = '{0, 64'd0, 64'd0, 64'd1000, 2002, 1'b0};
        vecs[1] = '{1, 64'd0, 64'd0, 64'd4503599627370496000, 2002, 1'b0};
        vecs[2] = '{2, 64'd0, 64'd0, 64'd0, 2002, 1'b1};

        for (int v = 0; v < 3; v++) begin
            logic [63:0] e;
            load(vecs[v].kind);
            e = vecs[v].use_model ? model(vecs[v].start_i, vecs[v].start_acc) : vecs[v].exp_result;
            run($sformatf("vec%0d", v), vecs[v].start_i, vecs[v].start_acc, e, vecs[v].exp_lat, 1'b0);
        end

        // Tail start: 5 + 3*-4 + 7*2 = 7, with a host write attempt while busy.
        host_wr(1'b1, 1'b1, 10'd998, 27'sd3, -27'sd4);
        host_wr(1'b1, 1'b1, 10'd999, 27'sd7, 27'sd2);
        run("tail", 64'd998, 64'd5, 64'd7, 6, 1'b1);
        controlArr       = 1'b1;
        controlArrAddr_a = 10'd999;
        tick();
        chk("busy_write_ignored", 64'(controlArrRData_a), 64'd7);

        // Start index past the end: no MAC, result is init_acc.
        run("skip", 64'd1000, -64'sd9, -64'sd9, 2, 1'b0);

        // Host write then readback one cycle after the address.
        host_wr(1'b1, 1'b0, 10'd5, 27'sd12345, 27'sd0);
        tick();
        chk("readback_a5", 64'(controlArrRData_a), 64'sd12345);
        chk("readback_b5", 64'(controlArrRData_b), 64'(ref_b[5]));

        // Start while host owns the memories is ignored.
        controlArr = 1'b1;
        r_enable   = 1'b1;
        tick();
        r_enable = 1'b0;
        hi = 0;
        repeat (10) begin
            tick();
            if (w_enable) hi++;
        end
        chk("host_start_ignored", 64'(hi), 64'd0);

        // Reset at cycle 100 of a run, then a clean re-run.
        init_i     = 64'd0;
        init_acc   = 64'd0;
        controlArr = 1'b0;
        r_enable   = 1'b1;
        hi = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            r_enable = 1'b0;
            if (w_enable) hi++;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrun_reset_result", result, 64'd0);
        chk("midrun_reset_w_enable", 64'(w_enable), 64'd0);
        repeat (2100) begin
            tick();
            if (w_enable) hi++;
        end
        chk("midrun_no_strobe", 64'(hi), 64'd0);
        run("rerun", 64'd0, 64'd0, model(64'd0, 64'd0), 2002, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
